// File: rtl/mips_pkg.sv
// Shared definitions for the ID-stage branch logic.
//   FWD_*    : comparator-source select encodings produced by the forwarding unit
//   REG_ZERO : architectural $zero, never a hazard source
//   DEF_DATA_W : default datapath width
//   ctr_state_e : stall counter state (IDLE when cnt==0, HOLD otherwise)
package mips_pkg;

  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
  localparam logic [1:0] FWD_REG_ALT = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } ctr_state_e;

endpackage

// File: rtl/id_branch_resolve_stall_ctr.sv
// branch_stall_ctr: down-counter that stretches load-use stalls on branches.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears the count)
//   need1      : hazard needing one bubble (no counter load)
//   need2      : hazard needing two bubbles (loads count of 1)
//   stall      : combinational stall request
module branch_stall_ctr
  import mips_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic need1,
  input  logic need2,
  output logic stall
);

  logic [CNT_W-1:0] r_cnt;
  ctr_state_e       w_state;

  assign w_state = (r_cnt == '0) ? ST_IDLE : ST_HOLD;

  // In HOLD the hazard inputs are ignored; in IDLE they are looked at fresh,
  // so a residual need1 after a count expires adds one more cycle.
  assign stall = (w_state == ST_HOLD) | need1 | need2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      case (w_state)
        ST_HOLD: r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= need2 ? CNT_W'(1) : '0;
      endcase
    end
  end

endmodule

// File: rtl/id_branch_resolve.sv
// id_branch_resolve: ID-stage branch resolution (beq/bne).
// Selects comparator operands from the forwarding selects, compares, computes
// the target, and drives PC redirect / IF-ID flush. Owns the stall counter for
// hazards that forwarding cannot cover.
// Optional macro BRANCH_STATS_EN adds saturating counters stat_resolved,
// stat_taken and stat_stall.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   ID_isbeq, ID_isbne             : branch decode (both set => beq)
//   IF_ID_rs, IF_ID_rt             : source registers
//   rs_data, rt_data               : register-file read data
//   r1ctrl, r2ctrl                 : operand selects (00/11 reg, 10 EX/MEM, 01 MEM/WB)
//   EX_MEM_ALUres, MEM_WB_MEMres   : forwarded values
//   ID_EX_*, EX_MEM_*              : downstream destination/control for hazard detect
//   IF_ID_pcplus4, IF_ID_imm       : target computation inputs
//   stall, pc_src, branch_target, if_id_flush : outputs
module id_branch_resolve
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ID_isbeq,
  input  logic              ID_isbne,
  input  logic [4:0]        IF_ID_rs,
  input  logic [4:0]        IF_ID_rt,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [1:0]        r1ctrl,
  input  logic [1:0]        r2ctrl,
  input  logic [DATA_W-1:0] EX_MEM_ALUres,
  input  logic [DATA_W-1:0] MEM_WB_MEMres,
  input  logic [4:0]        ID_EX_regres,
  input  logic              ID_EX_RegWrite,
  input  logic              ID_EX_MEMRead,
  input  logic [4:0]        EX_MEM_regres,
  input  logic              EX_MEM_RegWrite,
  input  logic              EX_MEM_MEMRead,
  input  logic [DATA_W-1:0] IF_ID_pcplus4,
  input  logic [15:0]       IF_ID_imm,
`ifdef BRANCH_STATS_EN
  output logic [DATA_W-1:0] stat_resolved,
  output logic [DATA_W-1:0] stat_taken,
  output logic [DATA_W-1:0] stat_stall,
`endif
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              if_id_flush
);

  function automatic logic dest_match(input logic [4:0] dest,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt);
    return (dest != REG_ZERO) && ((dest == rs) || (dest == rt));
  endfunction

  function automatic logic [DATA_W-1:0] sel_operand(input logic [1:0]        ctrl,
                                                    input logic [DATA_W-1:0] reg_v,
                                                    input logic [DATA_W-1:0] exmem_v,
                                                    input logic [DATA_W-1:0] memwb_v);
    case (ctrl)
      FWD_EXMEM: return exmem_v;
      FWD_MEMWB: return memwb_v;
      default:   return reg_v;   // FWD_REG and FWD_REG_ALT
    endcase
  endfunction

  logic              w_br;
  logic              w_need1;
  logic              w_need2;
  logic              w_stall;
  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  logic              w_eq;
  logic              w_taken;
  logic signed [DATA_W-1:0] w_offset;

  assign w_br = ID_isbeq | ID_isbne;

  // Load in EX: its data is two cycles away from being forwardable to ID.
  assign w_need2 = w_br & ID_EX_RegWrite & ID_EX_MEMRead
                 & dest_match(ID_EX_regres, IF_ID_rs, IF_ID_rt);

  // ALU op in EX, or load in MEM: one bubble makes it forwardable.
  assign w_need1 = w_br & (
      (ID_EX_RegWrite & ~ID_EX_MEMRead & dest_match(ID_EX_regres, IF_ID_rs, IF_ID_rt))
    | (EX_MEM_RegWrite & EX_MEM_MEMRead & dest_match(EX_MEM_regres, IF_ID_rs, IF_ID_rt)));

  branch_stall_ctr #(
    .CNT_W (CNT_W)
  ) u_stall_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .need1 (w_need1),
    .need2 (w_need2),
    .stall (w_stall)
  );

  assign w_opa = sel_operand(r1ctrl, rs_data, EX_MEM_ALUres, MEM_WB_MEMres);
  assign w_opb = sel_operand(r2ctrl, rt_data, EX_MEM_ALUres, MEM_WB_MEMres);
  assign w_eq  = (w_opa == w_opb);

  // beq takes precedence when both decode bits are set.
  assign w_taken = w_br & ~w_stall & (ID_isbeq ? w_eq : ~w_eq);

  assign w_offset = DATA_W'({{(DATA_W-18){IF_ID_imm[15]}}, IF_ID_imm, 2'b00});

  assign stall         = w_stall;
  assign pc_src        = w_taken;
  assign if_id_flush   = w_taken;
  assign branch_target = IF_ID_pcplus4 + w_offset;

`ifdef BRANCH_STATS_EN
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (&v) ? v : v + DATA_W'(1);
  endfunction

  logic [DATA_W-1:0] r_stat_resolved;
  logic [DATA_W-1:0] r_stat_taken;
  logic [DATA_W-1:0] r_stat_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_resolved <= '0;
      r_stat_taken    <= '0;
      r_stat_stall    <= '0;
    end else begin
      if (w_br & ~w_stall) r_stat_resolved <= sat_inc(r_stat_resolved);
      if (w_taken)         r_stat_taken    <= sat_inc(r_stat_taken);
      if (w_stall)         r_stat_stall    <= sat_inc(r_stat_stall);
    end
  end

  assign stat_resolved = r_stat_resolved;
  assign stat_taken    = r_stat_taken;
  assign stat_stall    = r_stat_stall;
`endif

endmodule
